// File: rtl/fifo_pkg.sv
// fifo_pkg
// Pointer coding helpers shared by the read- and write-side FIFO controllers.
// Both functions work on a 32-bit container: narrower pointers are
// zero-extended on the way in and truncated by the caller on the way out.
// Zero-extension does not change either conversion, so any width up to 32
// bits is handled.
package fifo_pkg;

    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/ptr_sync.sv
// ptr_sync
// Multi-flop bus synchronizer for a Gray-coded pointer crossing clock domains.
// Only one bit of the incoming bus may change at a time, so every bit can be
// synchronized independently without producing an invalid code.
// Ports:
//   clk       destination-domain clock
//   sync_rst  synchronous, active-high reset (clears every stage)
//   din       asynchronous Gray pointer from the source domain
//   dout      synchronized pointer, STAGES cycles behind din
module ptr_sync #(
    parameter int WDTH   = 4,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            sync_rst,
    input  logic [WDTH-1:0] din,
    output logic [WDTH-1:0] dout
);

    // The first stage is the metastability catcher; keep the chain together
    // and exclude it from timing via the CDC constraints.
    (* async_reg = "true" *) logic [WDTH-1:0] sync_ff [STAGES];

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_ff[i] <= '0;
            end
        end else begin
            sync_ff[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                sync_ff[i] <= sync_ff[i-1];
            end
        end
    end

    assign dout = sync_ff[STAGES-1];

endmodule

// File: rtl/rd_fifo_ctrl.sv
// rd_fifo_ctrl
// Read-side controller of the dual-clock FIFO. Synchronizes the write
// pointer, owns the read pointer, fetches from the synchronous-read RAM and
// presents words through a 2-entry first-word-fall-through output stage.
// Ports:
//   clk, sync_rst          read-domain clock, synchronous active-high reset
//   wr_ptr_gray            write pointer (Gray) from the write domain
//   rd_ptr_gray            registered Gray read pointer to the write domain
//   rd_ptr_bin             binary read pointer (source of ram_rd_addr)
//   ram_rd_en/addr/data    RAM read port, data one cycle after the strobe
//   dout, dout_vld, dout_rdy   head word with valid/ready handshake
//   empty                  no word presented
//   level                  words held: in RAM + in flight + buffered
module rd_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WDTH   = 4,
    parameter int DATA_WDTH   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 sync_rst,
    input  logic [ADDR_WDTH-1:0] wr_ptr_gray,
    output logic [ADDR_WDTH-1:0] rd_ptr_gray,
    output logic [ADDR_WDTH-1:0] rd_ptr_bin,
    output logic                 ram_rd_en,
    output logic [ADDR_WDTH-1:0] ram_rd_addr,
    input  logic [DATA_WDTH-1:0] ram_rd_data,
    output logic [DATA_WDTH-1:0] dout,
    output logic                 dout_vld,
    input  logic                 dout_rdy,
    output logic                 empty,
    output logic [ADDR_WDTH:0]   level
);

    logic [ADDR_WDTH-1:0] wr_gray_sync;
    logic [ADDR_WDTH-1:0] wr_ptr_sync;
    logic [ADDR_WDTH-1:0] rd_ptr;
    logic [ADDR_WDTH-1:0] rd_ptr_next;
    logic [ADDR_WDTH-1:0] ram_words;
    logic [DATA_WDTH-1:0] head;
    logic [DATA_WDTH-1:0] skid;
    logic [1:0]           occ;
    logic [1:0]           occ_after_pop;
    logic [2:0]           committed;
    logic                 infl;
    logic                 ptr_empty;
    logic                 pop;

    ptr_sync #(
        .WDTH   (ADDR_WDTH),
        .STAGES (SYNC_STAGES)
    ) u_wr_ptr_sync (
        .clk      (clk),
        .sync_rst (sync_rst),
        .din      (wr_ptr_gray),
        .dout     (wr_gray_sync)
    );

    assign wr_ptr_sync = ADDR_WDTH'(gray2bin(32'(wr_gray_sync)));
    assign ptr_empty   = (rd_ptr == wr_ptr_sync);

    assign pop           = (occ != 2'd0) & dout_rdy;
    assign occ_after_pop = occ - {1'b0, pop};

    // Slots already spoken for once this cycle's pop leaves; a new fetch is
    // only allowed while that count leaves room in the 2-entry stage.
    assign committed   = {1'b0, occ} + {2'b0, infl} - {2'b0, pop};
    assign ram_rd_en   = ~ptr_empty & (committed < 3'd2);
    assign ram_rd_addr = rd_ptr;
    assign rd_ptr_next = rd_ptr + ADDR_WDTH'(ram_rd_en);

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            rd_ptr      <= '0;
            rd_ptr_gray <= '0;
            occ         <= 2'd0;
            infl        <= 1'b0;
            head        <= '0;
            skid        <= '0;
        end else begin
            rd_ptr      <= rd_ptr_next;
            rd_ptr_gray <= ADDR_WDTH'(bin2gray(32'(rd_ptr_next)));
            infl        <= ram_rd_en;
            occ         <= occ_after_pop + {1'b0, infl};
            if (pop && (occ == 2'd2)) begin
                head <= skid;
            end
            // Arriving word goes to whichever entry is next in FIFO order.
            if (infl) begin
                if (occ_after_pop == 2'd0) begin
                    head <= ram_rd_data;
                end else begin
                    skid <= ram_rd_data;
                end
            end
        end
    end

    assign ram_words  = wr_ptr_sync - rd_ptr;
    assign level      = {1'b0, ram_words} + (ADDR_WDTH+1)'(infl) + (ADDR_WDTH+1)'(occ);
    assign rd_ptr_bin = rd_ptr;
    assign dout       = head;
    assign dout_vld   = (occ != 2'd0);
    assign empty      = ~dout_vld;

endmodule

// File: tb/tb_rd_fifo_ctrl.sv
// tb_rd_fifo_ctrl
// Drives rd_fifo_ctrl with a behavioural write side and RAM. The reference
// model is a queue of words written but not yet consumed; the expected level
// is the (delayed) write count minus the consumed count.
module tb_rd_fifo_ctrl;

   localparam int AW = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          sync_rst;
   logic [AW-1:0] wr_ptr_gray;
   logic [AW-1:0] rd_ptr_gray;
   logic [AW-1:0] rd_ptr_bin;
   logic          ram_rd_en;
   logic [AW-1:0] ram_rd_addr;
   logic [DW-1:0] ram_rd_data;
   logic [DW-1:0] dout;
   logic          dout_vld;
   logic          dout_rdy;
   logic          empty;
   logic [AW:0]   level;

   always #5 clk = ~clk;

   rd_fifo_ctrl #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .sync_rst    (sync_rst),
      .wr_ptr_gray (wr_ptr_gray),
      .rd_ptr_gray (rd_ptr_gray),
      .rd_ptr_bin  (rd_ptr_bin),
      .ram_rd_en   (ram_rd_en),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data),
      .dout        (dout),
      .dout_vld    (dout_vld),
      .dout_rdy    (dout_rdy),
      .empty       (empty),
      .level       (level)
   );

   logic [DW-1:0] mem [16];
   logic [AW-1:0] wr_bin;
   logic [AW-1:0] w_d1, w_d2;

   always @(posedge clk) begin
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
   end

   always @(posedge clk) begin
      w_d1 <= sync_rst ? '0 : wr_bin;
      w_d2 <= sync_rst ? '0 : w_d1;
   end

   int            vectors = 0;
   int            miscompares = 0;
   logic [DW-1:0] q [$];
   logic [AW-1:0] pop_pos;
   int            outstanding;
   bit            hold_chk;
   logic [AW-1:0] prev_gray;
   logic [AW-1:0] prev_bin;
   bit            saw_wrap;
   int            rd_en_cnt, rd_run, rd_max_run;
   int            pop_cnt, pop_run, pop_max_run;
   logic [DW-1:0] frozen;
   logic [AW-1:0] exp_ptr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write_word();
      mem[wr_bin] = 8'($urandom);
      q.push_back(mem[wr_bin]);
      wr_bin      = wr_bin + 1'b1;
      wr_ptr_gray = wr_bin ^ (wr_bin >> 1);
      outstanding++;
   endtask

   task automatic clear_counts();
      rd_en_cnt = 0; rd_run = 0; rd_max_run = 0;
      pop_cnt = 0; pop_run = 0; pop_max_run = 0;
   endtask

   task automatic check_cycle();
      if (q.size() == 0) chk("vld_when_model_empty", dout_vld, 1'b0);
      else if (dout_vld) chk("head_data", dout, q[0]);
      chk("level", level, {1'b0, 4'(w_d2 - pop_pos)});
      chk("gray_step", ($countones(rd_ptr_gray ^ prev_gray) <= 1), 1'b1);
      if (ram_rd_en) chk("read_past_write_ptr", (ram_rd_addr == w_d2), 1'b0);
      if (hold_chk) chk("vld_hold", dout_vld, 1'b1);
      if (prev_bin == 4'd15 && rd_ptr_bin == 4'd0) saw_wrap = 1'b1;
      if (ram_rd_en) begin
         rd_en_cnt++; rd_run++;
         if (rd_run > rd_max_run) rd_max_run = rd_run;
      end else rd_run = 0;
      if (dout_vld && dout_rdy) begin
         pop_cnt++; pop_run++;
         if (pop_run > pop_max_run) pop_max_run = pop_run;
         if (q.size() > 0) void'(q.pop_front());
         pop_pos = pop_pos + 1'b1;
         outstanding--;
      end else pop_run = 0;
      hold_chk  = dout_vld & ~dout_rdy;
      prev_gray = rd_ptr_gray;
      prev_bin  = rd_ptr_bin;
   endtask

   task automatic tick(input logic rdy, input bit wr);
      @(negedge clk);
      dout_rdy = rdy;
      if (wr && outstanding < 14) write_word();
      #1;
      check_cycle();
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      sync_rst = 1'b1;
      dout_rdy = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (i == 0) begin
            q.delete();
            for (int k = 0; k < int'(wr_bin); k++) q.push_back(mem[k]);
            pop_pos     = '0;
            outstanding = int'(wr_bin);
         end
         @(negedge clk);
         #1;
         chk("rst_vld", dout_vld, 1'b0);
         chk("rst_empty", empty, 1'b1);
         chk("rst_rd_en", ram_rd_en, 1'b0);
         chk("rst_level", level, 5'd0);
         chk("rst_dout", dout, 8'd0);
         chk("rst_rd_bin", rd_ptr_bin, 4'd0);
         chk("rst_rd_gray", rd_ptr_gray, 4'd0);
      end
      sync_rst  = 1'b0;
      hold_chk  = 1'b0;
      prev_gray = '0;
      prev_bin  = '0;
   endtask

   logic [1:0] exp_rd_en_seq [5];
   logic [1:0] exp_vld_seq   [5];

   initial begin
      sync_rst = 1'b1; dout_rdy = 1'b0;
      wr_bin = '0; wr_ptr_gray = '0; pop_pos = '0; outstanding = 0;
      hold_chk = 1'b0; prev_gray = '0; prev_bin = '0; saw_wrap = 1'b0;
      clear_counts();
      for (int k = 0; k < 16; k++) mem[k] = '0;

      for (int k = 0; k < 6; k++) write_word();
      do_reset(3);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      chk("level_after_rst", level, 5'd6);

      for (int k = 0; k < 12; k++) tick(1'b1, 1'b0);
      chk("drained_empty", empty, 1'b1);
      chk("drained_level", level, 5'd0);

      exp_rd_en_seq = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd0};
      exp_vld_seq   = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
      exp_ptr = wr_bin;
      tick(1'b0, 1'b1);
      for (int c = 1; c <= 4; c++) begin
         tick(1'b0, 1'b0);
         chk("single_rd_en", ram_rd_en, exp_rd_en_seq[c][0]);
         chk("single_vld", dout_vld, exp_vld_seq[c][0]);
         if (c == 2) chk("single_addr", ram_rd_addr, exp_ptr);
      end
      chk("single_level", level, 5'd1);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      chk("single_empty", empty, 1'b1);
      exp_ptr = exp_ptr + 1'b1;
      chk("single_gray", rd_ptr_gray, exp_ptr ^ (exp_ptr >> 1));

      clear_counts();
      for (int k = 0; k < 30; k++) tick(1'b1, k < 10);
      chk("stream_reads", rd_en_cnt, 10);
      chk("stream_read_run", rd_max_run, 10);
      chk("stream_pops", pop_cnt, 10);
      chk("stream_pop_run", pop_max_run, 10);

      clear_counts();
      for (int k = 0; k < 10; k++) tick(1'b0, 1'b1);
      for (int k = 0; k < 6; k++) tick(1'b0, 1'b0);
      frozen = dout;
      tick(1'b0, 1'b0);
      chk("bp_reads", rd_en_cnt, 2);
      chk("bp_level", level, 5'd10);
      chk("bp_frozen", dout, q[0]);
      chk("bp_frozen_hist", dout, frozen);
      clear_counts();
      for (int k = 0; k < 20; k++) tick(1'b1, 1'b0);
      chk("bp_drain_pops", pop_cnt, 10);

      saw_wrap = 1'b0;
      for (int k = 0; k < 400; k++) tick(1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
      chk("wrap_seen", saw_wrap, 1'b1);

      for (int k = 0; k < 8; k++) tick(1'b0, 1'b1);
      do_reset(1);
      for (int k = 0; k < 30; k++) tick(1'b1, 1'b0);
      chk("rst_full_drained", empty, 1'b1);

      for (int k = 0; k < 20; k++) begin
         tick(1'b1, 1'b1);
         if (ram_rd_en && dout_vld) break;
      end
      do_reset(1);
      for (int k = 0; k < 40; k++) tick(1'($urandom_range(0, 1)), 1'b0);
      for (int k = 0; k < 20; k++) tick(1'b1, 1'b0);
      chk("rst_infl_drained", empty, 1'b1);
      chk("rst_infl_level", level, 5'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
